// File: rtl/pipe_scroller.sv
// Scrolls N_PIPES obstacles left on each frame tick, updating one pipe per clock.
// Pipes leaving the screen wrap to the tail with a fresh LFSR gap; crossings of BIRD_X pulse score.
module pipe_scroller #(
    parameter int          N_PIPES        = 4,
    parameter int          X_WIDTH        = 10,
    parameter int          Y_WIDTH        = 9,
    parameter int          SPACING        = 160,
    parameter int          X_OFFSET       = 0,
    parameter int          SPEED          = 1,
    parameter int          BIRD_X         = 100,
    parameter int          GAP_MIN        = 64,
    parameter int          GAP_RANGE_LOG2 = 8,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         run,
    input  logic                         restart,
    input  logic                         frame_tick,
    output logic [N_PIPES*X_WIDTH-1:0]   pipe_x,
    output logic [N_PIPES*Y_WIDTH-1:0]   gap_y,
    output logic                         score_pulse,
    output logic                         busy,
    output logic                         overrun
);
    localparam int                 IDX_W    = $clog2(N_PIPES);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(N_PIPES - 1);
    localparam logic [X_WIDTH-1:0] SPEED_V  = X_WIDTH'(SPEED);
    localparam logic [X_WIDTH-1:0] BIRD_V   = X_WIDTH'(BIRD_X);
    // Old x is below SPEED on a wrap, so adding this constant stays under N_PIPES*SPACING.
    localparam logic [X_WIDTH-1:0] WRAP_ADD = X_WIDTH'(N_PIPES * SPACING - SPEED);
    localparam int                 GAP_STEP = (1 << GAP_RANGE_LOG2) / N_PIPES;

    if (N_PIPES * SPACING + X_OFFSET >= (1 << X_WIDTH)) begin : g_chk_x
        $error("pipe_scroller: N_PIPES*SPACING + X_OFFSET does not fit in X_WIDTH");
    end
    if (GAP_MIN + (1 << GAP_RANGE_LOG2) - 1 >= (1 << Y_WIDTH)) begin : g_chk_y
        $error("pipe_scroller: gap range does not fit in Y_WIDTH");
    end

    typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [X_WIDTH-1:0]   r_x  [N_PIPES];
    logic [Y_WIDTH-1:0]   r_gy [N_PIPES];
    logic [15:0]          r_lfsr;
    logic                 r_pending;
    logic                 r_overrun;
    logic                 r_busy;
    logic                 r_score;
    logic                 w_tick;
    logic                 w_pending_nxt;
    logic                 w_ovr_set;
    logic [15:0]          w_lfsr_nxt;
    logic [X_WIDTH-1:0]   w_old_x;
    logic [X_WIDTH-1:0]   w_new_x;
    logic [Y_WIDTH-1:0]   w_new_gap;
    logic                 w_wrap;
    logic                 w_cross;

    assign w_tick     = frame_tick & run;
    assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};

    assign w_old_x   = r_x[r_idx];
    assign w_wrap    = (w_old_x < SPEED_V);
    assign w_new_x   = w_wrap ? (w_old_x + WRAP_ADD) : (w_old_x - SPEED_V);
    assign w_new_gap = Y_WIDTH'(GAP_MIN) + Y_WIDTH'(r_lfsr[GAP_RANGE_LOG2-1:0]);
    assign w_cross   = !w_wrap && (w_old_x >= BIRD_V) && (w_new_x < BIRD_V);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_SWEEP);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_ovr_set     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pending || w_tick) begin
                    w_state_nxt   = S_SWEEP;
                    // A fresh tick arriving alongside a pending one is kept as the next pending.
                    w_pending_nxt = r_pending && w_tick;
                end
            end
            S_SWEEP, S_DONE: begin
                if (r_state == S_DONE) begin
                    w_state_nxt = S_IDLE;
                end else if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_DONE;
                end
                if (w_tick) begin
                    if (!r_pending) begin
                        w_pending_nxt = 1'b1;
                    end else begin
                        w_ovr_set = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (restart) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= w_lfsr_nxt;
        end

        if (rst || restart) begin
            for (int i = 0; i < N_PIPES; i++) begin
                r_x[i]  <= X_WIDTH'(X_OFFSET + i * SPACING);
                r_gy[i] <= Y_WIDTH'(GAP_MIN + i * GAP_STEP);
            end
            r_idx     <= '0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
            r_score   <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
            r_score <= 1'b0;
            if (r_state == S_IDLE) begin
                r_idx <= '0;
            end else if (r_state == S_SWEEP) begin
                r_x[r_idx] <= w_new_x;
                if (w_wrap) begin
                    r_gy[r_idx] <= w_new_gap;
                end
                r_score <= w_cross;
                if (r_idx != LAST_IDX) begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < N_PIPES; g++) begin : g_pack
        assign pipe_x[g*X_WIDTH +: X_WIDTH] = r_x[g];
        assign gap_y[g*Y_WIDTH +: Y_WIDTH]  = r_gy[g];
    end

    assign score_pulse = r_score;
    assign busy        = r_busy;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_pipe_scroller.sv
// Self-checking bench for pipe_scroller: randomized tick/run stimulus against a
// sweep-level model of pipe positions, gaps, score pulses, busy and overrun.
module tb_pipe_scroller;
    localparam int          N    = 4;
    localparam int          XW   = 10;
    localparam int          YW   = 9;
    localparam int          SP   = 160;
    localparam int          XO   = 0;
    localparam int          SPD  = 1;
    localparam int          BX   = 100;
    localparam int          GMIN = 64;
    localparam int          GL   = 8;
    localparam logic [15:0] SEED = 16'hACE1;

    logic            clk = 1'b0;
    logic            rst;
    logic            run;
    logic            restart;
    logic            frame_tick;
    logic [N*XW-1:0] pipe_x;
    logic [N*YW-1:0] gap_y;
    logic            score_pulse;
    logic            busy;
    logic            overrun;

    pipe_scroller #(
        .N_PIPES(N), .X_WIDTH(XW), .Y_WIDTH(YW), .SPACING(SP), .X_OFFSET(XO),
        .SPEED(SPD), .BIRD_X(BX), .GAP_MIN(GMIN), .GAP_RANGE_LOG2(GL), .LFSR_SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .restart(restart), .frame_tick(frame_tick),
        .pipe_x(pipe_x), .gap_y(gap_y), .score_pulse(score_pulse),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_pulses;
    logic [15:0] m_lfsr;
    logic [15:0] hist [0:4095];
    int          px [N];
    int          gy [N];

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        int   taps [4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        for (int k = 0; k < 4; k++) fb = fb ^ v[taps[k]-1];
        return {v[14:0], fb};
    endfunction

    // hist[e] holds the LFSR value in effect during the cycle that ends at edge e
    always @(posedge clk) begin
        hist[cyc % 4096] <= m_lfsr;
        m_lfsr           <= rst ? SEED : lfsr_step(m_lfsr);
        cyc              <= cyc + 1;
    end

    function automatic int get_x(input int i);
        return int'(pipe_x[i*XW +: XW]);
    endfunction

    function automatic int get_y(input int i);
        return int'(gap_y[i*YW +: YW]);
    endfunction

    function automatic void model_init();
        for (int i = 0; i < N; i++) begin
            px[i] = XO + i * SP;
            gy[i] = GMIN + i * ((1 << GL) / N);
        end
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (get_x(i) !== px[i]) begin
                errors++;
                $display("FAIL %s pipe_x[%0d] got %0d exp %0d", tag, i, get_x(i), px[i]);
            end
            checks++;
            if (get_y(i) !== gy[i]) begin
                errors++;
                $display("FAIL %s gap_y[%0d] got %0d exp %0d", tag, i, get_y(i), gy[i]);
            end
        end
    endtask

    // Issues n ticks (offsets 0, o1, o2 in cycles) and checks every cycle of the
    // resulting one or two sweeps; a second sweep starts N+2 edges after the first.
    task automatic do_ticks(input int n, input int o1, input int o2, input bit exp_ovr, input string tag);
        int tc, ns, last_j, e, ui, old, nw;
        int s [2];
        bit tk, bexp, pexp, in_upd;
        last_pulses = 0;
        @(negedge clk);
        tc     = cyc;
        ns     = (n > 1) ? 2 : 1;
        s[0]   = tc;
        s[1]   = tc + N + 2;
        last_j = (ns == 2) ? 2 * N + 4 : N + 3;
        for (int j = 0; j <= last_j; j++) begin
            if (j > 0) begin
                @(negedge clk);
                e = tc + j - 1;
                bexp = 1'b0; in_upd = 1'b0; pexp = 1'b0; ui = 0;
                for (int k = 0; k < ns; k++) begin
                    if (e >= s[k] && e <= s[k] + N - 1) bexp = 1'b1;
                    if (e >= s[k] + 1 && e <= s[k] + N) begin
                        in_upd = 1'b1;
                        ui = e - s[k] - 1;
                    end
                end
                if (in_upd) begin
                    old = px[ui];
                    if (old >= SPD) begin
                        nw   = old - SPD;
                        pexp = (old >= BX) && (nw < BX);
                    end else begin
                        nw     = old + N * SP - SPD;
                        gy[ui] = GMIN + int'(hist[e % 4096] & 16'((1 << GL) - 1));
                    end
                    px[ui] = nw;
                    checks++;
                    if (get_x(ui) !== px[ui]) begin
                        errors++;
                        $display("FAIL %s upd pipe_x[%0d] got %0d exp %0d", tag, ui, get_x(ui), px[ui]);
                    end
                    checks++;
                    if (get_y(ui) !== gy[ui]) begin
                        errors++;
                        $display("FAIL %s upd gap_y[%0d] got %0d exp %0d", tag, ui, get_y(ui), gy[ui]);
                    end
                end
                checks++;
                if (busy !== bexp) begin
                    errors++;
                    $display("FAIL %s busy@%0d got %b exp %b", tag, j, busy, bexp);
                end
                checks++;
                if (score_pulse !== pexp) begin
                    errors++;
                    $display("FAIL %s score_pulse@%0d got %b exp %b", tag, j, score_pulse, pexp);
                end
                if (score_pulse === 1'b1) last_pulses++;
            end
            tk = (j == 0) || (n > 1 && j == o1) || (n > 2 && j == o2);
            frame_tick = tk;
            run        = tk ? 1'b1 : 1'($urandom_range(0, 1));
            restart    = 1'b0;
        end
        frame_tick = 1'b0;
        check_all(tag);
        checks++;
        if (overrun !== exp_ovr) begin
            errors++;
            $display("FAIL %s overrun got %b exp %b", tag, overrun, exp_ovr);
        end
    endtask

    task automatic idle_gap();
        int g = $urandom_range(0, 3);
        for (int k = 0; k < g; k++) begin
            @(negedge clk);
            frame_tick = 1'($urandom_range(0, 1));
            run        = 1'b0;
        end
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; restart = 1'b0; frame_tick = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_init();
        check_all("reset");
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b exp 0", busy); end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL reset overrun got %b exp 0", overrun); end
        checks++;
        if (score_pulse !== 1'b0) begin errors++; $display("FAIL reset score_pulse got %b exp 0", score_pulse); end
    endtask

    task automatic test_scroll();
        do_ticks(1, 0, 0, 1'b0, "scroll");
        checks++;
        if (get_x(0) !== 639) begin errors++; $display("FAIL scroll wrap x got %0d exp 639", get_x(0)); end
        checks++;
        if (get_x(3) !== 479) begin errors++; $display("FAIL scroll pipe3 got %0d exp 479", get_x(3)); end
        checks++;
        if (get_y(0) < 64 || get_y(0) > 319) begin
            errors++;
            $display("FAIL scroll gap range got %0d exp 64..319", get_y(0));
        end
        checks++;
        if (last_pulses !== 0) begin errors++; $display("FAIL scroll pulses got %0d exp 0", last_pulses); end
    endtask

    task automatic test_run_low();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            run        = 1'b0;
            for (int w = 0; w < 1 + int'($urandom_range(0, 2)); w++) begin
                @(negedge clk);
                frame_tick = 1'b0;
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL run_low busy got %b exp 0", busy); end
            end
        end
        check_all("run_low");
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL run_low overrun got %b exp 0", overrun); end
    endtask

    task automatic test_back_to_back();
        do_ticks(2, 2, 0, 1'b0, "b2b");
        idle_gap();
        do_ticks(3, 1, 2, 1'b1, "overrun");
    endtask

    task automatic test_restart();
        idle_gap();
        @(negedge clk);
        frame_tick = 1'b1; run = 1'b1; restart = 1'b0;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        model_init();
        check_all("restart");
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL restart busy got %b exp 0", busy); end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL restart overrun got %b exp 0", overrun); end
        checks++;
        if (score_pulse !== 1'b0) begin errors++; $display("FAIL restart score got %b exp 0", score_pulse); end
        // restart and tick together: the tick must vanish
        @(negedge clk);
        restart = 1'b1; frame_tick = 1'b1; run = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            restart = 1'b0; frame_tick = 1'b0;
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL restart_tick busy got %b exp 0", busy); end
        end
        check_all("restart_tick");
        // pipe 0 wraps here; its gap must follow the free-running LFSR
        do_ticks(1, 0, 0, 1'b0, "post_restart");
    endtask

    task automatic test_score();
        int guard = 0;
        while (px[1] != BX && guard < 200) begin
            idle_gap();
            do_ticks(1, 0, 0, 1'b0, "approach");
            guard++;
        end
        checks++;
        if (px[1] != BX) begin errors++; $display("FAIL score approach got %0d exp %0d", px[1], BX); end
        idle_gap();
        do_ticks(1, 0, 0, 1'b0, "cross");
        checks++;
        if (last_pulses !== 1) begin errors++; $display("FAIL cross pulses got %0d exp 1", last_pulses); end
        checks++;
        if (get_x(1) !== BX - 1) begin errors++; $display("FAIL cross pipe1 got %0d exp %0d", get_x(1), BX - 1); end
        idle_gap();
        do_ticks(1, 0, 0, 1'b0, "after_cross");
        checks++;
        if (last_pulses !== 0) begin errors++; $display("FAIL after_cross pulses got %0d exp 0", last_pulses); end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; restart = 1'b0; frame_tick = 1'b0;
        test_reset();
        test_scroll();
        test_run_low();
        test_back_to_back();
        test_restart();
        test_score();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
